// File: rtl/weight_streamer.sv
// Read-side sequencer for a 1-cycle-latency weight ROM, streaming words through a 2-entry buffer.
// Optional backpressure counter on stall_cycles is built when WEIGHT_STREAMER_STALL_CNT_EN is defined.
module weight_streamer #(
    parameter int unsigned  DATA_WIDTH  = 32,
    parameter int unsigned  NUM_WEIGHTS = 10,
    parameter int unsigned  PASSES      = 1,
    localparam int unsigned AW          = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [AW-1:0]         m_index,
    output logic                  m_last,
    output logic [31:0]           stall_cycles
);
    localparam int unsigned   PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WEIGHTS - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [PW-1:0]         pass_q, pass_d;
    logic                  infl_q, infl_d;
    logic [AW-1:0]         infl_idx_q, infl_idx_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [AW-1:0]         idx0_q, idx0_d, idx1_q, idx1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pop, issue, new_last;
    logic [2:0]            level;

    // Next-state: buffer bookkeeping, read issue and job sequencing
    always_comb begin
        pop        = valid_q && m_ready;
        level      = 3'(occ_q) + 3'(infl_q) - 3'(pop);
        issue      = (state_q == S_FETCH) && (level < 3'd2);
        new_last   = (infl_idx_q == LAST_ADDR);
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        infl_d     = issue;
        infl_idx_d = infl_idx_q;
        occ_d      = occ_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        idx0_d     = idx0_q;
        idx1_d     = idx1_q;
        last0_d    = last0_q;
        last1_d    = last1_q;
        done_d     = 1'b0;

        // Entry 0 is the stream head; entry 1 only fills while the head is stalled
        case ({infl_q, pop})
            2'b01: begin
                data0_d = data1_q;
                idx0_d  = idx1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    data0_d = rom_dout;
                    idx0_d  = infl_idx_q;
                    last0_d = new_last;
                end else begin
                    data1_d = rom_dout;
                    idx1_d  = infl_idx_q;
                    last1_d = new_last;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = rom_dout;
                    idx0_d  = infl_idx_q;
                    last0_d = new_last;
                end else begin
                    data0_d = data1_q;
                    idx0_d  = idx1_q;
                    last0_d = last1_q;
                    data1_d = rom_dout;
                    idx1_d  = infl_idx_q;
                    last1_d = new_last;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != 2'd0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    infl_idx_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        if (pass_q == LAST_PASS) begin
                            pass_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            pass_d = pass_q + PW'(1);
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((occ_d == 2'd0) && !infl_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            occ_q      <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            idx0_q     <= '0;
            idx1_q     <= '0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            infl_q     <= infl_d;
            infl_idx_q <= infl_idx_d;
            occ_q      <= occ_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            idx0_q     <= idx0_d;
            idx1_q     <= idx1_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef WEIGHT_STREAMER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of stalled head cycles, restarted by each accepted job
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if (valid_q && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = addr_q;
    assign m_valid  = valid_q;
    assign m_data   = data0_q;
    assign m_index  = idx0_q;
    assign m_last   = last0_q;

endmodule

// File: tb/tb_weight_streamer.sv
// Bench for weight_streamer: PASSES=1 and PASSES=2 instances share stimulus and are checked
// every cycle against a word-count/head-index model, plus directed timing checks.
module tb_weight_streamer;
    localparam int DW = 32;
    localparam int NW = 10;
    localparam int AW = 4;
`ifdef WEIGHT_STREAMER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [AW-1:0] addr;
        logic          valid;
        logic [DW-1:0] data;
        logic [AW-1:0] index;
        logic          last;
        logic [31:0]   stall;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, m_ready;
    logic busy_a, done_a, m_valid_a, m_last_a, busy_b, done_b, m_valid_b, m_last_b;
    logic [AW-1:0] rom_addr_a, m_index_a, rom_addr_b, m_index_b;
    logic [DW-1:0] rom_dout_a, m_data_a, rom_dout_b, m_data_b;
    logic [31:0]   stall_a, stall_b;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    obs_t obs, ex;

    // Reference model state, one slot per instance (slot k runs k+1 passes)
    int m_job[2], m_done[2], m_fetch[2], m_addr[2], m_pass[2];
    int m_infl[2], m_iidx[2], m_cnt[2], m_head[2], m_stall[2];

    always #5 clk = ~clk;

    weight_streamer #(.DATA_WIDTH(DW), .NUM_WEIGHTS(NW), .PASSES(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .rom_addr(rom_addr_a), .rom_dout(rom_dout_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_data(m_data_a), .m_index(m_index_a), .m_last(m_last_a), .stall_cycles(stall_a));

    weight_streamer #(.DATA_WIDTH(DW), .NUM_WEIGHTS(NW), .PASSES(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .rom_addr(rom_addr_b), .rom_dout(rom_dout_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_data(m_data_b), .m_index(m_index_b), .m_last(m_last_b), .stall_cycles(stall_b));

    // Synchronous ROM, ROM[i] = i + 100
    always @(posedge clk) begin
        rom_dout_a <= 32'(rom_addr_a) + 32'd100;
        rom_dout_b <= 32'(rom_addr_b) + 32'd100;
    end

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_job[k] = 0; m_done[k] = 0; m_fetch[k] = 0; m_addr[k] = 0; m_pass[k] = 0;
            m_infl[k] = 0; m_iidx[k] = 0; m_cnt[k] = 0; m_head[k] = 0; m_stall[k] = 0;
        end
    endfunction

    function automatic void model_step(input bit st, input bit rdy);
        for (int k = 0; k < 2; k++) begin
            bit pop, iss;
            int lvl;
            pop = (m_cnt[k] > 0) && rdy;
            if (m_cnt[k] > 0 && !rdy) m_stall[k]++;
            lvl = m_cnt[k] + m_infl[k] - (pop ? 1 : 0);
            iss = (m_fetch[k] != 0) && (lvl < 2);
            if (pop) begin
                m_cnt[k]--;
                m_head[k] = (m_head[k] + 1) % NW;
            end
            if (m_infl[k] != 0) begin
                if (m_cnt[k] == 0) m_head[k] = m_iidx[k];
                m_cnt[k]++;
            end
            m_infl[k] = iss ? 1 : 0;
            if (iss) begin
                m_iidx[k] = m_addr[k];
                if (m_addr[k] == NW - 1) begin
                    m_addr[k] = 0;
                    m_pass[k]++;
                    if (m_pass[k] == k + 1) begin
                        m_pass[k]  = 0;
                        m_fetch[k] = 0;
                    end
                end else begin
                    m_addr[k]++;
                end
            end
            m_done[k] = 0;
            if (m_job[k] != 0) begin
                if (m_fetch[k] == 0 && m_cnt[k] == 0 && m_infl[k] == 0) begin
                    m_job[k]  = 0;
                    m_done[k] = 1;
                end
            end else if (st) begin
                m_job[k] = 1; m_fetch[k] = 1; m_addr[k] = 0; m_pass[k] = 0; m_stall[k] = 0;
            end
        end
    endfunction

    function automatic obs_t observe(input int k);
        obs_t o;
        if (k == 0) o = {busy_a, done_a, rom_addr_a, m_valid_a, m_data_a, m_index_a, m_last_a, stall_a};
        else        o = {busy_b, done_b, rom_addr_b, m_valid_b, m_data_b, m_index_b, m_last_b, stall_b};
        if (!o.valid) begin
            o.data  = '0;
            o.index = '0;
            o.last  = 1'b0;
        end
        return o;
    endfunction

    function automatic obs_t expect_out(input int k);
        obs_t e;
        e.busy  = (m_job[k] != 0);
        e.done  = (m_done[k] != 0);
        e.addr  = AW'(m_addr[k]);
        e.valid = (m_cnt[k] > 0);
        e.data  = e.valid ? DW'(m_head[k] + 100) : '0;
        e.index = e.valid ? AW'(m_head[k]) : '0;
        e.last  = e.valid && (m_head[k] == NW - 1);
        e.stall = STALL_EN ? 32'(m_stall[k]) : 32'd0;
        return e;
    endfunction

    // Drive one cycle of inputs (at negedge), advance the model, land on the next negedge
    task automatic cycle(input bit st, input bit rdy, input bit r);
        start   = st;
        m_ready = rdy;
        rst     = r;
        if (r) model_reset();
        else   model_step(st, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        for (int i = 0; i < 200; i++) begin
            if (m_job[0] == 0 && m_job[1] == 0) break;
            cycle(1'b0, 1'b1, 1'b0);
        end
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; m_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, m_valid_a, m_last_a, rom_addr_a, m_index_a, m_data_a, stall_a} !== '0) begin
            fails++;
            $display("FAIL reset_state_a: got busy=%b done=%b v=%b data=%h idx=%h addr=%h stall=%h, want all 0",
                     busy_a, done_a, m_valid_a, m_data_a, m_index_a, rom_addr_a, stall_a);
        end else passes++;
        checks++;
        if ({busy_b, done_b, m_valid_b, m_last_b, rom_addr_b, m_index_b, m_data_b, stall_b} !== '0) begin
            fails++;
            $display("FAIL reset_state_b: got busy=%b done=%b v=%b data=%h idx=%h addr=%h stall=%h, want all 0",
                     busy_b, done_b, m_valid_b, m_data_b, m_index_b, rom_addr_b, stall_b);
        end else passes++;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_single_pass();
        int first_v = -1, last_c = -1, done_c = -1, nd_a = 0, nd_b = 0, nw_a = 0, nw_b = 0, bad_a = 0, bad_b = 0;
        for (int c = 0; c < 30; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL single_pass inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            if (m_valid_a === 1'b1) begin
                if (first_v < 0) first_v = c;
                if (m_last_a === 1'b1) last_c = c;
                if (m_data_a !== 32'(nw_a + 100) || m_last_a !== (nw_a == NW - 1)) bad_a++;
                nw_a++;
            end
            if (m_valid_b === 1'b1) begin
                if (m_data_b !== 32'((nw_b % NW) + 100) || m_last_b !== ((nw_b % NW) == NW - 1)) bad_b++;
                nw_b++;
            end
            if (done_a === 1'b1) begin nd_a++; done_c = c; end
            if (done_b === 1'b1) nd_b++;
            cycle(c == 0, 1'b1, 1'b0);
        end
        checks++;
        if (first_v != 3 || last_c != 12) begin
            fails++; $display("FAIL latency: got first_valid=%0d last=%0d want 3 and 12", first_v, last_c);
        end else passes++;
        checks++;
        if (nd_a != 1 || done_c != 13) begin
            fails++; $display("FAIL done_pulse_a: got count=%0d cycle=%0d want 1 at 13", nd_a, done_c);
        end else passes++;
        checks++;
        if (nw_a != 10 || bad_a != 0) begin
            fails++; $display("FAIL words_a: got n=%0d bad=%0d want 10 and 0", nw_a, bad_a);
        end else passes++;
        checks++;
        if (nw_b != 20 || bad_b != 0 || nd_b != 1) begin
            fails++; $display("FAIL two_pass_b: got n=%0d bad=%0d dones=%0d want 20 0 1", nw_b, bad_b, nd_b);
        end else passes++;
    endtask

    task automatic test_toggle_ready();
        int nw_a = 0, nw_b = 0, bad = 0, unstable = 0;
        bit pend = 1'b0, rdy;
        logic [DW+AW:0] held = '0;
        for (int c = 0; c < 50; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL toggle inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            rdy = (c % 2 == 1);
            if (pend && (m_valid_a !== 1'b1 || {m_last_a, m_index_a, m_data_a} !== held)) unstable++;
            pend = (m_valid_a === 1'b1) && !rdy;
            held = {m_last_a, m_index_a, m_data_a};
            if (m_valid_a === 1'b1 && rdy) begin
                if (m_data_a !== 32'(nw_a + 100)) bad++;
                nw_a++;
            end
            if (m_valid_b === 1'b1 && rdy) begin
                if (m_data_b !== 32'((nw_b % NW) + 100)) bad++;
                nw_b++;
            end
            cycle(c == 0, rdy, 1'b0);
        end
        checks++;
        if (nw_a != 10 || nw_b != 20 || bad != 0) begin
            fails++; $display("FAIL toggle_words: got a=%0d b=%0d bad=%0d want 10 20 0", nw_a, nw_b, bad);
        end else passes++;
        checks++;
        if (unstable != 0) begin
            fails++; $display("FAIL toggle_hold: got %0d unstable stalls want 0", unstable);
        end else passes++;
        checks++;
        if (stall_a !== 32'(STALL_EN ? 9 : 0) || stall_b !== 32'(STALL_EN ? 19 : 0)) begin
            fails++; $display("FAIL stall_count: got a=%0d b=%0d want %0d %0d", stall_a, stall_b,
                              STALL_EN ? 9 : 0, STALL_EN ? 19 : 0);
        end else passes++;
    endtask

    task automatic test_long_stall();
        int nw = 0, bad = 0, held_bad = 0, first_hs = -1, last_hs = -1;
        logic [AW-1:0] addr20 = '0;
        bit rdy;
        for (int c = 0; c < 45; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL long_stall inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            rdy = (c > 20);
            if (c >= 3 && c <= 20 && (m_valid_a !== 1'b1 || m_data_a !== 32'd100)) held_bad++;
            if (c == 20) addr20 = rom_addr_a;
            if (m_valid_a === 1'b1 && rdy) begin
                if (m_data_a !== 32'(nw + 100)) bad++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                nw++;
            end
            cycle(c == 0, rdy, 1'b0);
        end
        checks++;
        if (held_bad != 0) begin
            fails++; $display("FAIL stall_hold: got %0d bad stall cycles want 0", held_bad);
        end else passes++;
        checks++;
        if (addr20 !== AW'(2)) begin
            fails++; $display("FAIL stall_depth: got rom_addr=%0d during stall want 2", addr20);
        end else passes++;
        checks++;
        if (nw != 10 || bad != 0 || first_hs != 21 || last_hs != 30) begin
            fails++; $display("FAIL stall_release: got n=%0d bad=%0d span=%0d..%0d want 10 0 21..30",
                              nw, bad, first_hs, last_hs);
        end else passes++;
    endtask

    task automatic test_mid_reset();
        int nd_a = 0, nd_b = 0, done_c = -1, nw = 0, bad = 0, first_hs = -1;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL mid_reset inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            if (c == 7) begin
                checks++;
                if ({busy_a, done_a, m_valid_a, m_last_a, rom_addr_a, m_index_a, m_data_a, stall_a,
                     busy_b, done_b, m_valid_b, m_last_b, rom_addr_b, m_index_b, m_data_b, stall_b} !== '0) begin
                    fails++;
                    $display("FAIL reset_abort: got a v=%b data=%h busy=%b, b v=%b data=%h busy=%b want all 0",
                             m_valid_a, m_data_a, busy_a, m_valid_b, m_data_b, busy_b);
                end else passes++;
            end
            if (done_a === 1'b1) begin nd_a++; done_c = c; end
            if (done_b === 1'b1) nd_b++;
            if (c >= 7 && m_valid_a === 1'b1) begin
                if (m_data_a !== 32'(nw + 100)) bad++;
                if (first_hs < 0) first_hs = c;
                nw++;
            end
            cycle(c == 0 || c == 8, 1'b1, c == 6);
        end
        checks++;
        if (nd_a != 1 || done_c != 21 || nd_b != 1) begin
            fails++; $display("FAIL reset_done: got a=%0d at %0d b=%0d want 1 at 21 and 1", nd_a, done_c, nd_b);
        end else passes++;
        checks++;
        if (nw != 10 || bad != 0 || first_hs != 11) begin
            fails++; $display("FAIL restart_words: got n=%0d bad=%0d first=%0d want 10 0 11", nw, bad, first_hs);
        end else passes++;
    endtask

    task automatic test_start_held();
        int nd_a = 0, nd_b = 0, bad = 0;
        logic busy14 = 1'b0;
        for (int c = 0; c < 45; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL start_held inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            if (done_a === 1'b1) begin
                nd_a++;
                if (c % 13 != 0) bad++;
            end
            if (done_b === 1'b1) nd_b++;
            if (c == 14) busy14 = busy_a;
            cycle(c < 40, 1'b1, 1'b0);
        end
        checks++;
        if (nd_a != 3 || bad != 0 || nd_b != 1) begin
            fails++; $display("FAIL back_to_back: got a=%0d bad=%0d b=%0d want 3 0 1", nd_a, bad, nd_b);
        end else passes++;
        checks++;
        if (busy14 !== 1'b1) begin
            fails++; $display("FAIL restart_busy: got busy=%b after done want 1", busy14);
        end else passes++;
    endtask

    task automatic test_random();
        bit st, rdy, r;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                obs = observe(k); ex = expect_out(k); checks++;
                if (obs !== ex) begin
                    fails++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h", k, c, obs, ex);
                end else passes++;
            end
            st  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 299) == 0);
            cycle(st, rdy, r);
        end
    endtask

    initial begin
        test_reset();
        settle();
        test_single_pass();
        settle();
        test_toggle_ready();
        settle();
        test_long_stall();
        settle();
        test_mid_reset();
        settle();
        test_start_held();
        settle();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
